util_cdc_tx: RTL
================

Name: util_cdc_tx

Overview:
- Source-side sender for multi-bit clock-domain crossings using a 2-phase (toggle) req/ack handshake.
- Takes words from a local valid/ready stream and holds them stable on cdc_data_o.
- Signals each word by toggling cdc_req_o, then waits for the toggle-ack from the destination domain; that ack is synchronized internally.
- Sits at the launching end of CDC paths; the destination-side capture logic synchronizes cdc_req_o with the 2-flop util_sync chain.

Parameters:
- WIDTH, 32, payload width in bits.
- SYNC_STAGES, 2, flops in the internal ack synchronizer chain; legal values 2..4.

Ports:
- clk_i  in  1  local clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- tx_valid_i  in  1  local word valid.
- tx_ready_o  out  1  local word accepted when tx_valid_i && tx_ready_o at an edge.
- tx_data_i  in  WIDTH  local word.
- cdc_req_o  out  1  request toggle toward the destination domain; registered, glitch-free.
- cdc_data_o  out  WIDTH  payload toward the destination; registered; stable whenever cdc_req_o != synchronized ack.
- cdc_ack_i  in  1  ack toggle from the destination domain; asynchronous to clk_i.
- busy_o  out  1  high while a transfer is outstanding (state != IDLE) or the holding buffer is full.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (reset_i high at an edge):
  - state=IDLE, cdc_req_o=0, cdc_data_o=0, buffer empty, ack sync chain all 0, err_o=0, busy_o=0.
  - tx_ready_o is 0 while reset_i is high and 1 in the first cycle after reset is released.
  - Reset mid-transfer abandons the word. The destination must be reset in the same system reset so both toggles restart at 0.
- Ack synchronizer: SYNC_STAGES-flop chain on cdc_ack_i. Its last stage is ack_s; a further register ack_q detects change. Only ack_s is used in the logic.
- Holding buffer: one entry (buf_valid, buf_data). tx_ready_o = !buf_valid && !reset_i; the output is combinational from registers only, with no dependency on tx_valid_i.
- FSM states IDLE, SETUP, WAIT:
  - IDLE: on accept, cdc_data_o <= tx_data_i, go to SETUP. Buffer is always empty in IDLE.
  - SETUP (exactly 1 cycle; data settles before req moves): cdc_req_o <= ~cdc_req_o, go to WAIT.
  - WAIT: completion when ack_s == cdc_req_o. On completion:
    - buffer full: cdc_data_o <= buf_data, buf_valid <= 0, go to SETUP.
    - else if accept this cycle: cdc_data_o <= tx_data_i (bypass, not stored in buffer), go to SETUP.
    - else: go to IDLE.
  - SETUP, or WAIT without completion: an accept writes buf_data/buf_valid.
- Ordering: words leave in acceptance order; no drops, no duplicates.
- Throughput:
  - Minimum per word is 1 (SETUP) + destination sync/response latency + SYNC_STAGES + 1 cycles.
  - With an immediately responding ack, max rate is one word per SYNC_STAGES+2 cycles.
- cdc_data_o changes only on the IDLE->SETUP or WAIT->SETUP edges, i.e. only when ack_s == cdc_req_o.
- err_o is set when ack_s != ack_q while state != WAIT (ack toggle with nothing outstanding). It stays set until reset; data flow continues unaffected.
- ack_s changing twice within one WAIT is not detectable and is out of protocol.

Test Plan:
- Single word: reset, tx_data_i=0xDEADBEEF with valid for 1 cycle; bench acks by toggling cdc_ack_i 3 cycles after seeing req.
  - cdc_data_o=0xDEADBEEF one cycle before cdc_req_o goes 0->1.
  - tx_ready_o stays 1; busy_o drops SYNC_STAGES+1 cycles after the ack toggle.
- Back-to-back stream: 0x1,0x2,0x3,0x4 with valid held; ack responds 2 cycles after req.
  - cdc_req_o toggles 4 times, ending at 0; cdc_data_o sequence is 1,2,3,4.
  - tx_ready_o drops while the buffer is full.
- Bypass: buffer empty; tx_valid_i=1 (data 0xA5) in the exact completion cycle.
  - 0xA5 appears on cdc_data_o next edge; buf_valid stays 0; SETUP entered.
- Backpressure: ack withheld for 50 cycles with valid held.
  - One word on cdc_data_o, one in the buffer, tx_ready_o=0 for the remainder; cdc_data_o stable throughout.
- Reset mid-transfer: reset_i pulsed during WAIT with buffer full.
  - Next cycle: cdc_req_o=0, cdc_data_o=0, tx_ready_o=1, busy_o=0, err_o=0.
- Spurious ack: toggle cdc_ack_i while IDLE.
  - err_o=1 SYNC_STAGES+1 cycles later and stays 1.
  - A subsequent transfer still completes correctly once the bench ack polarity is realigned.

Source files
------------

// File: rtl/util_cdc_tx.sv
// Source side of a 2-phase toggle req/ack crossing: a word is held on cdc_data_o, then req toggles a cycle later.
// One word per SYNC_STAGES+2 cycles at best; a one-entry buffer absorbs one extra word, then tx_ready_o drops.
module util_cdc_tx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic             cdc_req_o,
    output logic [WIDTH-1:0] cdc_data_o,
    input  logic             cdc_ack_i,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT
    } state_t;

    state_t                 state, state_nxt;
    logic                   req_q, req_nxt;
    logic [WIDTH-1:0]       data_q, data_nxt;
    logic                   buf_valid, buf_valid_nxt;
    logic [WIDTH-1:0]       buf_data, buf_data_nxt;
    logic                   err_q, err_nxt;

    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   ack_q;
    logic                   accept;
    logic                   done;

    // cdc_ack_i is asynchronous; only the last stage feeds any logic.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ack_sync <= '0;
            ack_q    <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], cdc_ack_i};
            ack_q    <= ack_s;
        end
    end

    assign ack_s      = ack_sync[SYNC_STAGES-1];
    assign tx_ready_o = !buf_valid && !reset_i;
    assign accept     = tx_valid_i && tx_ready_o;
    assign done       = (ack_s == req_q);

    always_comb begin
        state_nxt     = state;
        req_nxt       = req_q;
        data_nxt      = data_q;
        buf_valid_nxt = buf_valid;
        buf_data_nxt  = buf_data;
        err_nxt       = err_q | ((ack_s != ack_q) && (state != WAIT));
        case (state)
            IDLE: begin
                if (accept) begin
                    data_nxt  = tx_data_i;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                // data was launched last cycle, so req can move now without a skew hazard
                req_nxt   = ~req_q;
                state_nxt = WAIT;
                if (accept) begin
                    buf_data_nxt  = tx_data_i;
                    buf_valid_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (done) begin
                    if (buf_valid) begin
                        data_nxt      = buf_data;
                        buf_valid_nxt = 1'b0;
                        state_nxt     = SETUP;
                    end else if (accept) begin
                        data_nxt  = tx_data_i;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (accept) begin
                    buf_data_nxt  = tx_data_i;
                    buf_valid_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            data_q    <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_q     <= req_nxt;
            data_q    <= data_nxt;
            buf_valid <= buf_valid_nxt;
            buf_data  <= buf_data_nxt;
            err_q     <= err_nxt;
        end
    end

    assign cdc_req_o  = req_q;
    assign cdc_data_o = data_q;
    assign busy_o     = (state != IDLE) || buf_valid;
    assign err_o      = err_q;

endmodule
